imem_line_responder: RTL and testbench

//  Instruction-side responder serving the prefetch unit's word requests (req/addr in, ack/r_data out).

---
 rtl/imem_resp_pkg.sv | 32 +++
 rtl/imem_line_buf.sv | 40 ++++
 rtl/imem_line_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_imem_line_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_resp_pkg.sv
// ---------------------------------------------------------------------------
// imem_resp_pkg
// Shared definitions for the instruction-side line responder:
//   - state_e      : responder FSM states (IDLE, REFILL, RESP)
//   - INSTR_NOP    : word presented on rdata_o out of reset (addi x0,x0,0)
//   - LINE_WORDS_DEF : default number of words held in the line buffer
//   - idxWidth / tagWidth : helpers deriving the word-index and tag widths
//     from the data width and line size
// Optional feature macro used by the top: IMEM_RESP_PERF_EN
// ---------------------------------------------------------------------------
package imem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic [31:0] INSTR_NOP      = 32'h0000_0013;
    localparam int          LINE_WORDS_DEF = 4;

    // Number of address bits that select a word inside one line.
    function automatic int idxWidth(input int lineWords);
        return $clog2(lineWords);
    endfunction

    // Address bits above the word index and the byte offset form the tag.
    function automatic int tagWidth(input int xlen, input int lineWords);
        return xlen - $clog2(lineWords) - 2;
    endfunction

endpackage

// File: rtl/imem_line_buf.sv
// ---------------------------------------------------------------------------
// imem_line_buf
// Storage for one instruction line: LINE_WORDS words of XLEN bits.
// One synchronous write port fed by refill beats and one asynchronous read
// port addressed by word index.
// Ports:
//   clk      in   clock, write happens on the rising edge
//   we_i     in   write enable (one refill beat)
//   waddr_i  in   word index written
//   wdata_i  in   beat data
//   raddr_i  in   word index read
//   rdata_o  out  word at raddr_i (combinational)
// ---------------------------------------------------------------------------
module imem_line_buf
    import imem_resp_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                            clk,
    input  logic                            we_i,
    input  logic [idxWidth(LINE_WORDS)-1:0] waddr_i,
    input  logic [XLEN-1:0]                 wdata_i,
    input  logic [idxWidth(LINE_WORDS)-1:0] raddr_i,
    output logic [XLEN-1:0]                 rdata_o
);

    logic [XLEN-1:0] words_q [LINE_WORDS];

    // The line contents need no reset: the responder's valid bit guarantees
    // nothing is read from the buffer before a full refill has written it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            words_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = words_q[raddr_i];

endmodule

// File: rtl/imem_line_responder.sv
// ---------------------------------------------------------------------------
// imem_line_responder
// Answers instruction word requests from the prefetch unit out of a single
// line buffer. Hits are acknowledged the cycle after the request; misses
// refill the whole line from a beat-serial memory bus (base word first) and
// acknowledge one cycle after the last beat.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   req_i         request, held by the requester until ack_o
//   addr_i        physical byte address (bits [1:0] ignored)
//   flush_i       invalidate the line buffer
//   ack_o         one-cycle response strobe
//   rdata_o       instruction word, valid with ack_o
//   mem_req_o     refill request, high for the whole refill
//   mem_addr_o    line-aligned refill base address
//   mem_ack_i     one beat returned per cycle it is high (during refill)
//   mem_rdata_i   beat data
//   hit_cnt_o     (IMEM_RESP_PERF_EN only) saturating hit counter
//   miss_cnt_o    (IMEM_RESP_PERF_EN only) saturating miss counter
// Configuration macro: IMEM_RESP_PERF_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module imem_line_responder
    import imem_resp_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic            flush_i,
    output logic            ack_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i
`ifdef IMEM_RESP_PERF_EN
    ,
    output logic [31:0]     hit_cnt_o,
    output logic [31:0]     miss_cnt_o
`endif
);

    localparam int IDX_W = idxWidth(LINE_WORDS);
    localparam int TAG_W = tagWidth(XLEN, LINE_WORDS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    state_e             state_q,     state_d;
    logic               lineValid_q, lineValid_d;
    logic [TAG_W-1:0]   tag_q,       tag_d;
    logic [IDX_W-1:0]   beatCnt_q,   beatCnt_d;
    logic [TAG_W-1:0]   reqTag_q,    reqTag_d;
    logic [IDX_W-1:0]   reqWord_q,   reqWord_d;
    logic               drop_q,      drop_d;
    logic               suppress_q,  suppress_d;
    logic               ack_q,       ack_d;
    logic [XLEN-1:0]    rdata_q,     rdata_d;
    logic               memReq_q,    memReq_d;
    logic [XLEN-1:0]    memAddr_q,   memAddr_d;

    logic [IDX_W-1:0]   addrWord;
    logic [TAG_W-1:0]   addrTag;
    logic               lineHit;
    logic               bufWe;
    logic [IDX_W-1:0]   bufRaddr;
    logic [XLEN-1:0]    bufRdata;
    logic               unusedAddrBits;

    assign addrWord       = addr_i[IDX_W+1:2];
    assign addrTag        = addr_i[XLEN-1:IDX_W+2];
    assign unusedAddrBits = ^addr_i[1:0];
    assign lineHit        = lineValid_q && (addrTag == tag_q);

    // In RESP the answer comes from the word latched at miss time; otherwise
    // the live request address selects the word for a hit.
    assign bufRaddr = (state_q == RESP) ? reqWord_q : addrWord;

    imem_line_buf #(
        .XLEN       (XLEN),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (bufWe),
        .waddr_i (beatCnt_q),
        .wdata_i (mem_rdata_i),
        .raddr_i (bufRaddr),
        .rdata_o (bufRdata)
    );

    // Next-state logic. Everything holds by default and ack_d drops, so the
    // strobe lasts exactly one cycle unless a new hit is evaluated.
    // A miss clears line_valid immediately because the refill overwrites the
    // buffer in place. drop_q remembers a flush seen mid-refill (the bus
    // cannot abort, so beats are still consumed but the line stays invalid);
    // suppress_q remembers that the requester abandoned or changed its
    // request, in which case the line is kept but no ack is given.
    always_comb begin
        state_d     = state_q;
        lineValid_d = lineValid_q;
        tag_d       = tag_q;
        beatCnt_d   = beatCnt_q;
        reqTag_d    = reqTag_q;
        reqWord_d   = reqWord_q;
        drop_d      = drop_q;
        suppress_d  = suppress_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;
        memReq_d    = memReq_q;
        memAddr_d   = memAddr_q;
        bufWe       = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    lineValid_d = 1'b0;
                end else if (req_i) begin
                    if (lineHit) begin
                        ack_d   = 1'b1;
                        rdata_d = bufRdata;
                    end else begin
                        state_d     = REFILL;
                        lineValid_d = 1'b0;
                        reqTag_d    = addrTag;
                        reqWord_d   = addrWord;
                        beatCnt_d   = '0;
                        drop_d      = 1'b0;
                        suppress_d  = 1'b0;
                        memReq_d    = 1'b1;
                        memAddr_d   = {addrTag, {(IDX_W+2){1'b0}}};
                    end
                end
            end

            REFILL: begin
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                if (!req_i || (addrTag != reqTag_q) || (addrWord != reqWord_q)) begin
                    suppress_d = 1'b1;
                end
                if (mem_ack_i) begin
                    bufWe     = 1'b1;
                    beatCnt_d = beatCnt_q + 1'b1;
                    if (beatCnt_q == LAST_BEAT) begin
                        memReq_d = 1'b0;
                        if (drop_q || flush_i) begin
                            lineValid_d = 1'b0;
                            state_d     = IDLE;
                        end else begin
                            lineValid_d = 1'b1;
                            tag_d       = reqTag_q;
                            state_d     = RESP;
                        end
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
                if (flush_i) begin
                    lineValid_d = 1'b0;
                end else if (!suppress_q && req_i &&
                             (addrTag == reqTag_q) && (addrWord == reqWord_q)) begin
                    ack_d   = 1'b1;
                    rdata_d = bufRdata;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset returns every control register to its idle
    // value, which also abandons any refill in flight; stray bus beats after
    // that are ignored because they only count in REFILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lineValid_q <= 1'b0;
            tag_q       <= '0;
            beatCnt_q   <= '0;
            reqTag_q    <= '0;
            reqWord_q   <= '0;
            drop_q      <= 1'b0;
            suppress_q  <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= XLEN'(INSTR_NOP);
            memReq_q    <= 1'b0;
            memAddr_q   <= '0;
        end else begin
            state_q     <= state_d;
            lineValid_q <= lineValid_d;
            tag_q       <= tag_d;
            beatCnt_q   <= beatCnt_d;
            reqTag_q    <= reqTag_d;
            reqWord_q   <= reqWord_d;
            drop_q      <= drop_d;
            suppress_q  <= suppress_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            memReq_q    <= memReq_d;
            memAddr_q   <= memAddr_d;
        end
    end

    assign ack_o      = ack_q;
    assign rdata_o    = rdata_q;
    assign mem_req_o  = memReq_q;
    assign mem_addr_o = memAddr_q;

`ifdef IMEM_RESP_PERF_EN
    logic        hitInc;
    logic        missInc;
    logic [31:0] hitCnt_q;
    logic [31:0] missCnt_q;

    assign hitInc  = (state_q == IDLE) && !flush_i && req_i && lineHit;
    assign missInc = (state_q == IDLE) && !flush_i && req_i && !lineHit;

    // Performance counters: one hit per IDLE hit ack, one miss per refill
    // started. They saturate instead of wrapping and survive flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else begin
            if (hitInc && (hitCnt_q != 32'hFFFF_FFFF)) begin
                hitCnt_q <= hitCnt_q + 32'd1;
            end
            if (missInc && (missCnt_q != 32'hFFFF_FFFF)) begin
                missCnt_q <= missCnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hitCnt_q;
    assign miss_cnt_o = missCnt_q;
`else
    // Counters not built: the functional path above is unchanged.
`endif

endmodule

// File: tb/tb_imem_line_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_line_responder
// Self-checking bench for imem_line_responder. A bus model answers refills
// with data derived from the beat address; expected response words are
// queued when a request is driven and popped when ack_o appears.
// Build with IMEM_RESP_PERF_EN defined to also check the counters.
// ---------------------------------------------------------------------------
module tb_imem_line_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        flush;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        memAck;
    logic [31:0] memRdata;
`ifdef IMEM_RESP_PERF_EN
    logic [31:0] hitCnt;
    logic [31:0] missCnt;
`endif

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] expQ[$];
    int          stallBetween = 0;
    bit          strayAck     = 1'b0;

    imem_line_responder dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .addr_i      (addr),
        .flush_i     (flush),
        .ack_o       (ack_o),
        .rdata_o     (rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (memAck),
        .mem_rdata_i (memRdata)
`ifdef IMEM_RESP_PERF_EN
        ,
        .hit_cnt_o   (hitCnt),
        .miss_cnt_o  (missCnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents seen by the bus model. Line 0x8000_0000 holds
    // 0x11,0x22,0x33,0x44; everything else is address-derived.
    function automatic logic [31:0] modelWord(input logic [31:0] a);
        if (a[31:4] == 28'h800_0000) begin
            return 32'h11 * (32'(a[3:2]) + 32'd1);
        end
        return {a[15:0], ~a[15:0]};
    endfunction

    // Bus model: drives beats on the falling edge while mem_req_o is high,
    // base word first, optionally stalling between beats.
    initial begin
        int  bmBeat    = 0;
        int  stallLeft = 0;
        bit  realAck   = 1'b0;
        memAck   = 1'b0;
        memRdata = '0;
        forever begin
            @(negedge clk);
            if (realAck) bmBeat = bmBeat + 1;
            realAck = 1'b0;
            if (strayAck) begin
                memAck   = 1'b1;
                memRdata = 32'hBAD0_BAD0;
            end else if (!mem_req_o || rst) begin
                memAck    = 1'b0;
                bmBeat    = 0;
                stallLeft = 0;
            end else if (stallLeft > 0) begin
                memAck    = 1'b0;
                stallLeft = stallLeft - 1;
            end else begin
                memAck    = 1'b1;
                realAck   = 1'b1;
                memRdata  = modelWord(mem_addr_o + 32'(bmBeat * 4));
                stallLeft = stallBetween;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; flush = 1'b0; addr = '0;
        repeat (3) step();
        testsRun++;
        if (ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes: got ack=%b mem_req=%b expected 0 0", ack_o, mem_req_o);
        end
        testsRun++;
        if (rdata_o !== NOP || mem_addr_o !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: got rdata=%h mem_addr=%h expected %h 0", rdata_o, mem_addr_o, NOP);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_miss();
        int lat;
        logic [31:0] exp;
        addr = 32'h8000_0004; req = 1'b1;
        expQ.push_back(modelWord(addr));
        step(); lat = 1;
        testsRun++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0000) begin
            testsFailed++;
            $display("[TB] FAIL miss_issue: got mem_req=%b addr=%h expected 1 80000000", mem_req_o, mem_addr_o);
        end
        while (ack_o !== 1'b1 && lat < 40) begin step(); lat++; end
        testsRun++;
        if (lat != 6) begin
            testsFailed++;
            $display("[TB] FAIL miss_latency: got %0d expected 6", lat);
        end
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
        testsRun++;
        if (rdata_o !== exp || exp !== 32'h22) begin
            testsFailed++;
            $display("[TB] FAIL miss_data: got %h expected %h (0x22)", rdata_o, exp);
        end
        req = 1'b0;
        step();
        testsRun++;
        if (ack_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL miss_single_ack: got ack=%b expected 0", ack_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        addr = 32'h8000_0008; req = 1'b1;
        expQ.push_back(modelWord(addr));
        step();
        exp = expQ.pop_front();
        testsRun++;
        if (ack_o !== 1'b1 || mem_req_o !== 1'b0 || rdata_o !== exp) begin
            testsFailed++;
            $display("[TB] FAIL hit1: got ack=%b mem_req=%b rdata=%h expected 1 0 %h", ack_o, mem_req_o, rdata_o, exp);
        end
        addr = 32'h8000_000C;
        expQ.push_back(modelWord(addr));
        step();
        exp = expQ.pop_front();
        testsRun++;
        if (ack_o !== 1'b1 || mem_req_o !== 1'b0 || rdata_o !== exp) begin
            testsFailed++;
            $display("[TB] FAIL hit2: got ack=%b mem_req=%b rdata=%h expected 1 0 %h", ack_o, mem_req_o, rdata_o, exp);
        end
        req = 1'b0;
        step();
        testsRun++;
        if (ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL hit_idle: got ack=%b mem_req=%b expected 0 0", ack_o, mem_req_o);
        end
`ifdef IMEM_RESP_PERF_EN
        testsRun++;
        if (missCnt !== 32'd1 || hitCnt !== 32'd2) begin
            testsFailed++;
            $display("[TB] FAIL perf_counts: got miss=%0d hit=%0d expected 1 2", missCnt, hitCnt);
        end
`endif
    endtask

    task automatic test_flush_refill();
        int lat;
        logic reqAt4 = 1'b0;
        logic reqAt5 = 1'b1;
        logic ackSeen = 1'b0;
        logic [31:0] exp;
        addr = 32'h8000_0010; req = 1'b1;
        step();
        testsRun++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8000_0010) begin
            testsFailed++;
            $display("[TB] FAIL flush_issue: got mem_req=%b addr=%h expected 1 80000010", mem_req_o, mem_addr_o);
        end
        step();
        flush = 1'b1; req = 1'b0;
        step();
        flush = 1'b0;
        for (int i = 3; i <= 10; i++) begin
            if (i == 4) reqAt4 = mem_req_o;
            if (i == 5) reqAt5 = mem_req_o;
            ackSeen = ackSeen | ack_o;
            step();
        end
        testsRun++;
        if (reqAt4 !== 1'b1 || reqAt5 !== 1'b0 || ackSeen !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_drain: got req@4=%b req@5=%b ack=%b expected 1 0 0", reqAt4, reqAt5, ackSeen);
        end
        req = 1'b1;
        expQ.push_back(modelWord(addr));
        step(); lat = 1;
        testsRun++;
        if (mem_req_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flush_rerefill: got mem_req=%b expected 1", mem_req_o);
        end
        while (ack_o !== 1'b1 && lat < 40) begin step(); lat++; end
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
        testsRun++;
        if (lat != 6 || rdata_o !== exp) begin
            testsFailed++;
            $display("[TB] FAIL flush_refill_resp: got lat=%0d rdata=%h expected 6 %h", lat, rdata_o, exp);
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_stall();
        int lat;
        logic [31:0] exp;
        stallBetween = 3;
        addr = 32'h8000_0028; req = 1'b1;
        expQ.push_back(modelWord(addr));
        step(); lat = 1;
        while (ack_o !== 1'b1 && lat < 60) begin step(); lat++; end
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
        testsRun++;
        if (lat != 15) begin
            testsFailed++;
            $display("[TB] FAIL stall_latency: got %0d expected 15", lat);
        end
        testsRun++;
        if (rdata_o !== exp) begin
            testsFailed++;
            $display("[TB] FAIL stall_data: got %h expected %h", rdata_o, exp);
        end
        req = 1'b0; stallBetween = 0;
        step();
    endtask

    task automatic test_flush_hit();
        int lat;
        logic [31:0] exp;
        addr = 32'h8000_0020; req = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0;
        testsRun++;
        if (ack_o !== 1'b0 || mem_req_o !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flushhit_noack: got ack=%b mem_req=%b expected 0 0", ack_o, mem_req_o);
        end
        expQ.push_back(modelWord(addr));
        step(); lat = 2;
        testsRun++;
        if (mem_req_o !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flushhit_refill: got mem_req=%b expected 1", mem_req_o);
        end
        while (ack_o !== 1'b1 && lat < 40) begin step(); lat++; end
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
        testsRun++;
        if (lat != 7 || rdata_o !== exp) begin
            testsFailed++;
            $display("[TB] FAIL flushhit_resp: got lat=%0d rdata=%h expected 7 %h", lat, rdata_o, exp);
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_abandon();
        logic ackSeen = 1'b0;
        logic [31:0] exp;
        addr = 32'h8000_0054; req = 1'b1;
        step(); step();
        req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ackSeen = ackSeen | ack_o;
            step();
        end
        testsRun++;
        if (ackSeen !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abandon_noack: got ack=%b expected 0", ackSeen);
        end
        addr = 32'h8000_0058; req = 1'b1;
        expQ.push_back(modelWord(addr));
        step();
        exp = expQ.pop_front();
        testsRun++;
        if (ack_o !== 1'b1 || mem_req_o !== 1'b0 || rdata_o !== exp) begin
            testsFailed++;
            $display("[TB] FAIL abandon_hit: got ack=%b mem_req=%b rdata=%h expected 1 0 %h", ack_o, mem_req_o, rdata_o, exp);
        end
        req = 1'b0;
        step();
    endtask

    task automatic test_reset_midrefill();
        int lat;
        logic [31:0] exp;
        addr = 32'h8000_0040; req = 1'b1;
        step(); step();
        rst = 1'b1; req = 1'b0;
        step();
        testsRun++;
        if (ack_o !== 1'b0 || mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || rdata_o !== NOP) begin
            testsFailed++;
            $display("[TB] FAIL midreset: got ack=%b mem_req=%b addr=%h rdata=%h expected 0 0 0 %h",
                     ack_o, mem_req_o, mem_addr_o, rdata_o, NOP);
        end
`ifdef IMEM_RESP_PERF_EN
        testsRun++;
        if (hitCnt !== 32'd0 || missCnt !== 32'd0) begin
            testsFailed++;
            $display("[TB] FAIL perf_reset: got hit=%0d miss=%0d expected 0 0", hitCnt, missCnt);
        end
`endif
        rst = 1'b0; strayAck = 1'b1;
        step(); step();
        strayAck = 1'b0;
        step();
        addr = 32'h8000_0004; req = 1'b1;
        expQ.push_back(modelWord(addr));
        step(); lat = 1;
        while (ack_o !== 1'b1 && lat < 40) begin step(); lat++; end
        exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hxxxx_xxxx;
        testsRun++;
        if (lat != 6 || rdata_o !== exp) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_refill: got lat=%0d rdata=%h expected 6 %h", lat, rdata_o, exp);
        end
        req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_miss();
        test_back_to_back();
        test_flush_refill();
        test_stall();
        test_flush_hit();
        test_abandon();
        test_reset_midrefill();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
